// File: rtl/uart_cmd_bridge.sv
// Bridges a byte-oriented UART command stream ('W'/'R' frames) onto a 32-bit
// memory port, polling TX_COUNT_H before every response byte.
module uart_cmd_bridge #(
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [2:0]  uart_address,
  output logic [7:0]  uart_data_o,
  output logic        uart_wr,
  output logic        uart_enable,
  input  logic [7:0]  uart_data_i,
  input  logic        uart_ready,
  input  logic        uart_rx_ready_int,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_o,
  output logic        mem_wr,
  output logic        mem_enable,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ready
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  localparam logic [2:0] UA_BUF   = 3'd0;
  localparam logic [2:0] UA_CNT_H = 3'd2;

  typedef enum logic [3:0] {
    IDLE, RX_REQ, RX_WAIT, DECODE, MEM_REQ, MEM_WAIT,
    TXCHK_REQ, TXCHK_WAIT, TX_REQ, TX_WAIT
  } state_t;

  state_t          state;
  logic [3:0]      byte_cnt;
  logic [7:0]      opcode;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [31:0]     tx_buf;
  logic [2:0]      tx_left;
  logic [TW-1:0]   tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      opcode       <= '0;
      addr         <= '0;
      wdata        <= '0;
      tx_buf       <= '0;
      tx_left      <= '0;
      tmo_cnt      <= '0;
      uart_address <= '0;
      uart_data_o  <= '0;
      uart_wr      <= 1'b0;
      uart_enable  <= 1'b0;
      mem_address  <= '0;
      mem_data_o   <= '0;
      mem_wr       <= 1'b0;
      mem_enable   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (uart_rx_ready_int) state <= RX_REQ;
        end

        // Waits here for the next frame byte; only mid-frame waits can time out.
        RX_REQ: begin
          if (uart_rx_ready_int) begin
            uart_enable  <= 1'b1;
            uart_address <= UA_BUF;
            uart_wr      <= 1'b0;
            state        <= RX_WAIT;
          end else if (byte_cnt != 4'd0) begin
            if (tmo_cnt == TMO_LAST) begin
              byte_cnt <= '0;
              tmo_cnt  <= '0;
              state    <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end

        RX_WAIT: begin
          if (uart_ready) begin
            uart_enable <= 1'b0;
            tmo_cnt     <= '0;
            byte_cnt    <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd0)      opcode <= uart_data_i;
            else if (byte_cnt <= 4'd4) addr   <= {addr[23:0], uart_data_i};
            else                       wdata  <= {wdata[23:0], uart_data_i};
            state <= DECODE;
          end
        end

        DECODE: begin
          if (byte_cnt == 4'd1 && opcode != OP_W && opcode != OP_R) begin
            byte_cnt <= '0;
            tx_buf   <= {NAK, 24'h0};
            tx_left  <= 3'd1;
            state    <= TXCHK_REQ;
          end else if ((opcode == OP_R && byte_cnt == 4'd5) ||
                       (opcode == OP_W && byte_cnt == 4'd9)) begin
            byte_cnt <= '0;
            state    <= MEM_REQ;
          end else begin
            state <= RX_REQ;
          end
        end

        MEM_REQ: begin
          mem_enable  <= 1'b1;
          mem_address <= addr;
          mem_wr      <= (opcode == OP_W);
          mem_data_o  <= wdata;
          state       <= MEM_WAIT;
        end

        MEM_WAIT: begin
          if (mem_ready) begin
            mem_enable <= 1'b0;
            mem_wr     <= 1'b0;
            if (opcode == OP_W) begin
              tx_buf  <= {ACK, 24'h0};
              tx_left <= 3'd1;
            end else begin
              tx_buf  <= mem_data_i;
              tx_left <= 3'd4;
            end
            state <= TXCHK_REQ;
          end
        end

        TXCHK_REQ: begin
          uart_enable  <= 1'b1;
          uart_address <= UA_CNT_H;
          uart_wr      <= 1'b0;
          state        <= TXCHK_WAIT;
        end

        // A non-zero TX_COUNT_H means the TX FIFO is full: poll again.
        TXCHK_WAIT: begin
          if (uart_ready) begin
            uart_enable <= 1'b0;
            state       <= (uart_data_i == 8'h00) ? TX_REQ : TXCHK_REQ;
          end
        end

        TX_REQ: begin
          uart_enable  <= 1'b1;
          uart_address <= UA_BUF;
          uart_wr      <= 1'b1;
          uart_data_o  <= tx_buf[31:24];
          state        <= TX_WAIT;
        end

        TX_WAIT: begin
          if (uart_ready) begin
            uart_enable <= 1'b0;
            uart_wr     <= 1'b0;
            tx_buf      <= {tx_buf[23:0], 8'h00};
            tx_left     <= tx_left - 3'd1;
            state       <= (tx_left == 3'd1) ? IDLE : TXCHK_REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Scoreboard bench: stimulus queues RX bytes and expected memory/TX traffic,
// behavioural UART and memory slaves pop and compare as the bridge acts.
module tb_uart_cmd_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  uart_address;
  logic [7:0]  uart_data_o;
  logic        uart_wr;
  logic        uart_enable;
  logic [7:0]  uart_data_i;
  logic        uart_ready;
  logic        uart_rx_ready_int;
  logic [31:0] mem_address;
  logic [31:0] mem_data_o;
  logic        mem_wr;
  logic        mem_enable;
  logic [31:0] mem_data_i;
  logic        mem_ready;

  always #5 clk = ~clk;

  uart_cmd_bridge #(.TIMEOUT(100)) dut (
    .clk               (clk),
    .rst               (rst),
    .uart_address      (uart_address),
    .uart_data_o       (uart_data_o),
    .uart_wr           (uart_wr),
    .uart_enable       (uart_enable),
    .uart_data_i       (uart_data_i),
    .uart_ready        (uart_ready),
    .uart_rx_ready_int (uart_rx_ready_int),
    .mem_address       (mem_address),
    .mem_data_o        (mem_data_o),
    .mem_wr            (mem_wr),
    .mem_enable        (mem_enable),
    .mem_data_i        (mem_data_i),
    .mem_ready         (mem_ready)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } mem_op_t;

  logic [7:0] rxq[$];
  logic [7:0] exp_tx[$];
  mem_op_t    exp_mem[$];

  int  vectors     = 0;
  int  miscompares = 0;
  int  busy_polls  = 0;
  int  polls_seen  = 0;
  bit  last_full   = 1'b0;
  bit  mem_hold    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic rx(input logic [7:0] b);
    rxq.push_back(b);
  endtask

  task automatic frame_w(input logic [31:0] a, input logic [31:0] d);
    mem_op_t op;
    rx(8'h57);
    for (int i = 3; i >= 0; i--) rx(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) rx(d[i*8 +: 8]);
    op.addr = a; op.wr = 1'b1; op.data = d;
    exp_mem.push_back(op);
    exp_tx.push_back(8'h06);
  endtask

  task automatic frame_r_hdr(input logic [31:0] a, input logic [31:0] rd);
    mem_op_t op;
    op.addr = a; op.wr = 1'b0; op.data = rd;
    exp_mem.push_back(op);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[i*8 +: 8]);
  endtask

  task automatic frame_r(input logic [31:0] a, input logic [31:0] rd);
    rx(8'h52);
    for (int i = 3; i >= 0; i--) rx(a[i*8 +: 8]);
    frame_r_hdr(a, rd);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((rxq.size() != 0 || exp_tx.size() != 0 || exp_mem.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
    repeat (10) @(negedge clk);
  endtask

  // UART slave: one wait state, then a single-cycle uart_ready pulse.
  initial begin
    uart_ready        = 1'b0;
    uart_data_i       = 8'h00;
    uart_rx_ready_int = 1'b0;
    forever begin
      @(negedge clk);
      uart_ready = 1'b0;
      if (uart_enable && !rst) begin
        @(negedge clk);
        if (uart_enable && !rst) begin
          if (!uart_wr && uart_address == 3'd0) begin
            if (rxq.size() == 0) begin
              chk("rx_read_when_empty", 32'd1, 32'd0);
              uart_data_i = 8'h00;
            end else begin
              uart_data_i = rxq.pop_front();
            end
          end else if (!uart_wr && uart_address == 3'd2) begin
            polls_seen++;
            if (busy_polls > 0) begin
              busy_polls--;
              uart_data_i = 8'h01;
              last_full   = 1'b1;
            end else begin
              uart_data_i = 8'h00;
              last_full   = 1'b0;
            end
          end else if (uart_wr && uart_address == 3'd0) begin
            chk("tx_while_fifo_full", {31'd0, last_full}, 32'd0);
            if (exp_tx.size() == 0) chk("unexpected_tx", {24'd0, uart_data_o}, 32'hFFFF_FFFF);
            else                    chk("tx_byte", {24'd0, uart_data_o}, {24'd0, exp_tx.pop_front()});
            last_full = 1'b1;
          end else begin
            chk("bad_uart_access", {28'd0, uart_wr, uart_address}, 32'hFFFF_FFFF);
          end
          uart_ready = 1'b1;
        end
      end
      uart_rx_ready_int = (rxq.size() != 0);
    end
  end

  // Memory slave: one wait state, compares each access against the scoreboard.
  initial begin
    mem_ready  = 1'b0;
    mem_data_i = 32'h0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_enable && !mem_hold && !rst) begin
        @(negedge clk);
        if (mem_enable && !mem_hold && !rst) begin
          if (exp_mem.size() == 0) begin
            chk("unexpected_mem", mem_address, 32'hFFFF_FFFF);
          end else begin
            mem_op_t op;
            op = exp_mem.pop_front();
            chk("mem_addr", mem_address, op.addr);
            chk("mem_wr", {31'd0, mem_wr}, {31'd0, op.wr});
            if (op.wr) chk("mem_wdata", mem_data_o, op.data);
            else       mem_data_i = op.data;
          end
          mem_ready = 1'b1;
        end
      end
    end
  end

  task automatic chk_outputs_zero(input string name);
    chk({name, "_uart_enable"}, {31'd0, uart_enable}, 32'd0);
    chk({name, "_uart_wr"},     {31'd0, uart_wr}, 32'd0);
    chk({name, "_uart_addr"},   {29'd0, uart_address}, 32'd0);
    chk({name, "_uart_data"},   {24'd0, uart_data_o}, 32'd0);
    chk({name, "_mem_enable"},  {31'd0, mem_enable}, 32'd0);
    chk({name, "_mem_wr"},      {31'd0, mem_wr}, 32'd0);
    chk({name, "_mem_addr"},    mem_address, 32'd0);
    chk({name, "_mem_data"},    mem_data_o, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Word write, then ACK.
    frame_w(32'h0000_1000, 32'hDEAD_BEEF);
    drain("write");

    // Word read, with a second frame already queued during the response.
    frame_r(32'h0000_1000, 32'h1234_5678);
    frame_w(32'h0000_2000, 32'hCAFE_F00D);
    drain("read_then_write");

    // Bad opcode gives NAK only; the following frame still parses.
    rx(8'hA5);
    exp_tx.push_back(8'h15);
    frame_w(32'h0000_0004, 32'h0000_002A);
    drain("nak");

    // Partial frame abandoned after the inter-byte timeout.
    rx(8'h52);
    rx(8'h00);
    repeat (150) @(negedge clk);
    chk("timeout_no_mem", exp_mem.size(), 32'd0);
    chk("timeout_no_tx", exp_tx.size(), 32'd0);
    chk("timeout_mem_idle", {31'd0, mem_enable}, 32'd0);

    // Full read with a sub-timeout gap and a TX FIFO full for 50 polls.
    polls_seen = 0;
    busy_polls = 50;
    rx(8'h52);
    rx(8'h00);
    repeat (60) @(negedge clk);
    rx(8'h00);
    rx(8'h00);
    rx(8'h08);
    frame_r_hdr(32'h0000_0008, 32'hA1B2_C3D4);
    drain("busy_read");
    chk("txchk_polls", polls_seen, 32'd54);

    // Reset in the middle of a memory handshake.
    mem_hold = 1'b1;
    rx(8'h52);
    for (int i = 0; i < 3; i++) rx(8'h00);
    rx(8'h0C);
    for (int i = 0; i < 500 && !mem_enable; i++) @(negedge clk);
    chk("pre_rst_mem_enable", {31'd0, mem_enable}, 32'd1);
    chk("pre_rst_mem_addr", mem_address, 32'h0000_000C);
    rst = 1'b1;
    @(negedge clk);
    chk_outputs_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    mem_hold = 1'b0;
    repeat (3) @(negedge clk);

    frame_r(32'h0000_0010, 32'h55AA_0FF0);
    drain("post_rst_read");

    chk("final_rxq_empty", rxq.size(), 32'd0);
    chk("final_tx_empty", exp_tx.size(), 32'd0);
    chk("final_mem_empty", exp_mem.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_bridge.md
UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000000, inter-byte timeout in clk cycles within a frame.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port uart_address  output  3  UART register address (0 = RX/TX buffer, 1 = TX_COUNT_L, 2 = TX_COUNT_H).
REQ-005 SHALL have port uart_data_o  output  8  byte to UART.
REQ-006 SHALL have port uart_wr  output  1  1 = write, 0 = read.
REQ-007 SHALL have port uart_enable  output  1  UART access request.
REQ-008 SHALL have port uart_data_i  input  8  byte from UART.
REQ-009 SHALL have port uart_ready  input  1  UART access complete.
REQ-010 SHALL have port uart_rx_ready_int  input  1  RX FIFO non-empty.
REQ-011 SHALL have port mem_address  output  32  memory word address.
REQ-012 SHALL have port mem_data_o  output  32  write data.
REQ-013 SHALL have port mem_wr  output  1  1 = write, 0 = read.
REQ-014 SHALL have port mem_enable  output  1  memory access request.
REQ-015 SHALL have port mem_data_i  input  32  read data.
REQ-016 SHALL have port mem_ready  input  1  memory access complete.

Function
REQ-017 SHALL master the UART slave port: hold enable, address, wr and data stable until uart_ready=1; drop uart_enable in the cycle after uart_ready is seen; keep uart_enable low for at least 1 cycle between accesses.
REQ-018 SHALL issue a UART read of address 0 only when uart_rx_ready_int=1, and capture uart_data_i in the cycle uart_ready=1.
REQ-019 SHALL parse frames in this order: opcode byte, then 4 address bytes MSB first, then, for write only, 4 data bytes MSB first.
REQ-020 SHALL accept opcodes 0x57 ('W', word write) and 0x52 ('R', word read).
REQ-021 SHALL, on any other opcode, transmit 0x15 (NAK), consume no further bytes for that frame, and return to IDLE.
REQ-022 SHALL, after a complete frame, run one memory access with mem_enable held until mem_ready=1, then deassert mem_enable the next cycle; mem_data_i is captured on mem_ready.
REQ-023 SHALL respond to 'W' with the single byte 0x06 (ACK), sent only after mem_ready.
REQ-024 SHALL respond to 'R' with the 4 read-data bytes, MSB first.
REQ-025 SHALL, before each TX byte, read TX_COUNT_H, write to address 0 only if the returned value is 0 (TX FIFO not full), and otherwise re-read TX_COUNT_H.
REQ-026 SHALL use states IDLE, RX_REQ, RX_WAIT, DECODE, MEM_REQ, MEM_WAIT, TXCHK_REQ, TXCHK_WAIT, TX_REQ, TX_WAIT.
REQ-027 SHALL transition IDLE -> RX_REQ on uart_rx_ready_int; on the last response byte go TX_WAIT -> IDLE.
REQ-028 SHALL run the inter-byte counter while mid-frame (at least 1 byte received, frame incomplete) and waiting for uart_rx_ready_int; reset the counter on each received byte.
REQ-029 SHALL, when the inter-byte counter reaches TIMEOUT, discard the partial frame, send no response, and go to IDLE.
REQ-030 SHALL apply no timeout to memory or UART handshakes; they wait indefinitely.
REQ-031 SHALL track byte count with a 4-bit counter, shift-assemble address and data registers, and pass address bits through unmodified.
REQ-032 SHALL, when uart_rx_ready_int is high during a response, defer the next frame until after IDLE.

Reset
REQ-033 SHALL, on rst, go to IDLE and clear uart_enable, uart_wr, mem_enable, mem_wr, byte counter, timeout counter, uart_address, uart_data_o, mem_address and mem_data_o to 0.
REQ-034 SHALL give rst priority over every state, including mid-handshake; an in-flight access is abandoned, with enable low in the cycle after rst is sampled.

Verification
REQ-035 SHALL cover: RX bytes 57 00 00 10 00 DE AD BE EF -> one memory write at address 0x00001000 with data 0xDEADBEEF, mem_wr=1, then TX byte 0x06.
REQ-036 SHALL cover: RX 52 00 00 10 00 with memory returning 0x12345678 -> memory read at 0x00001000, then TX 12 34 56 78 in that order.
REQ-037 SHALL cover: RX byte 0xA5 -> TX 0x15, no mem_enable pulse, next frame parsed correctly.
REQ-038 SHALL cover: RX 52 00 then silence for TIMEOUT cycles (TIMEOUT=100) -> no memory access, no TX, state IDLE; a subsequent full 'R' frame succeeds.
REQ-039 SHALL cover: TX_COUNT_H returns 1 for 50 polls during the 'R' response -> no write to address 0 until it returns 0; all 4 bytes still delivered in order.
REQ-040 SHALL cover: rst asserted while mem_enable=1 and mem_ready=0 -> mem_enable=0 the next cycle, all outputs 0, state IDLE.
